// File: rtl/shop_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : shop_cmd_driver
// Purpose : Scripted command initiator that waits for each expected shop prompt,
//           then presents the scripted command/user index and strobes o_rdy.
// Revision: 1.0
// ============================================================================
module shop_cmd_driver #(
   parameter int I_A_NUM_ASCII_CHARS = 7,
   parameter int O_A_NUM_ASCII_CHARS = 9,
   parameter int I_U_NUM_BITS        = 4,
   parameter int NUM_STEPS           = 8,
   parameter int STEP_BITS           = 3,
   parameter int SETUP_CYCLES        = 1,
   parameter int TIMEOUT_CYCLES      = 64
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic                             i_ld_we,
   input  logic [STEP_BITS-1:0]             i_ld_idx,
   input  logic [O_A_NUM_ASCII_CHARS*8-1:0] i_ld_prompt,
   input  logic [I_A_NUM_ASCII_CHARS*8-1:0] i_ld_cmd,
   input  logic [I_U_NUM_BITS-1:0]          i_ld_u,
   input  logic [STEP_BITS:0]               i_num_steps,
   input  logic                             i_start,
   input  logic [O_A_NUM_ASCII_CHARS*8-1:0] i_prompt,
   output logic                             o_rdy,
   output logic [I_U_NUM_BITS-1:0]          o_u,
   output logic [I_A_NUM_ASCII_CHARS*8-1:0] o_a,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_err,
   output logic [STEP_BITS-1:0]             o_step,
   output logic [O_A_NUM_ASCII_CHARS*8-1:0] o_err_prompt
);

   localparam int c_PW = O_A_NUM_ASCII_CHARS*8;
   localparam int c_CW = I_A_NUM_ASCII_CHARS*8;
   localparam logic [15:0]          c_TMO_LAST   = 16'(TIMEOUT_CYCLES-1);
   localparam logic [3:0]           c_SETUP_LAST = 4'(SETUP_CYCLES-1);
   localparam logic [STEP_BITS:0]   c_MAX_STEPS  = (STEP_BITS+1)'(NUM_STEPS);
   localparam logic [STEP_BITS:0]   c_ONE_N      = (STEP_BITS+1)'(1);
   localparam logic [STEP_BITS-1:0] c_STEP_ONE   = STEP_BITS'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [c_PW-1:0]         r_ram_prompt [NUM_STEPS];
   logic [c_CW-1:0]         r_ram_cmd    [NUM_STEPS];
   logic [I_U_NUM_BITS-1:0] r_ram_u      [NUM_STEPS];

   logic [STEP_BITS-1:0]    r_step;
   logic [STEP_BITS-1:0]    r_last;
   logic [15:0]             r_tmo;
   logic [3:0]              r_setup_cnt;
   logic [c_CW-1:0]         r_a;
   logic [I_U_NUM_BITS-1:0] r_u;
   logic [c_PW-1:0]         r_err_prompt;

   logic [c_PW-1:0]         w_ent_prompt;
   logic                    w_match;
   logic                    w_tmo_hit;
   logic                    w_setup_done;
   logic                    w_last_step;
   logic                    w_busy;
   logic [STEP_BITS-1:0]    w_last;

   assign w_ent_prompt = r_ram_prompt[r_step];
   assign w_busy = (r_state == S_WAIT) || (r_state == S_SETUP) ||
                   (r_state == S_STROBE) || (r_state == S_HOLD);

   // Script storage is deliberately left out of reset so a replay after reset reuses it.
   always_ff @(posedge i_clk) begin
      if (i_ld_we && !w_busy && (int'(i_ld_idx) < NUM_STEPS)) begin
         r_ram_prompt[i_ld_idx] <= i_ld_prompt;
         r_ram_cmd[i_ld_idx]    <= i_ld_cmd;
         r_ram_u[i_ld_idx]      <= i_ld_u;
      end
   end

   always_comb begin
      w_last = '0;
      if (i_num_steps == '0) begin
         w_last = '0;
      end else if (i_num_steps > c_MAX_STEPS) begin
         w_last = STEP_BITS'(c_MAX_STEPS - c_ONE_N);
      end else begin
         w_last = STEP_BITS'(i_num_steps - c_ONE_N);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_match      = (w_ent_prompt == '0) || (w_ent_prompt == i_prompt);
      w_tmo_hit    = (r_tmo == c_TMO_LAST);
      w_setup_done = (r_setup_cnt == c_SETUP_LAST);
      w_last_step  = (r_step == r_last);
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (i_start) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_match)        w_state_nxt = S_SETUP;
            else if (w_tmo_hit) w_state_nxt = S_ERR;
         end
         S_SETUP: begin
            if (w_setup_done) w_state_nxt = S_STROBE;
         end
         S_STROBE: w_state_nxt = S_HOLD;
         S_HOLD:   w_state_nxt = w_last_step ? S_DONE : S_WAIT;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_step       <= '0;
         r_last       <= '0;
         r_tmo        <= '0;
         r_setup_cnt  <= '0;
         r_a          <= '0;
         r_u          <= '0;
         r_err_prompt <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (i_start) begin
                  r_step       <= '0;
                  r_last       <= w_last;
                  r_tmo        <= '0;
                  r_err_prompt <= '0;
               end
            end
            S_WAIT: begin
               if (w_match) begin
                  r_a         <= r_ram_cmd[r_step];
                  r_u         <= r_ram_u[r_step];
                  r_setup_cnt <= '0;
               end else if (w_tmo_hit) begin
                  r_err_prompt <= i_prompt;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
            end
            S_SETUP: begin
               if (!w_setup_done) r_setup_cnt <= r_setup_cnt + 4'd1;
            end
            S_HOLD: begin
               if (!w_last_step) begin
                  r_step <= r_step + c_STEP_ONE;
                  r_tmo  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_rdy        = (r_state == S_STROBE);
   assign o_busy       = w_busy;
   assign o_done       = (r_state == S_DONE);
   assign o_err        = (r_state == S_ERR);
   assign o_step       = r_step;
   assign o_a          = r_a;
   assign o_u          = r_u;
   assign o_err_prompt = r_err_prompt;

endmodule
`default_nettype wire

// File: tb/tb_shop_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_shop_cmd_driver
// Purpose : Directed bench with a stub shop prompt and an expected-command queue.
// Revision: 1.0
// ============================================================================
module tb_shop_cmd_driver;

   localparam logic [71:0] P_CMD   = 72'("Cmd?");
   localparam logic [71:0] P_USER  = 72'("Username?");
   localparam logic [71:0] P_PASS  = 72'("Password?");
   localparam logic [71:0] P_INVAL = 72'("InvalCmd");
   localparam logic [71:0] P_GARB  = 72'("Garbage");
   localparam logic [55:0] C_LOGIN = 56'("Login");
   localparam logic [55:0] C_ADM   = 56'("Adm");
   localparam logic [55:0] C_123   = 56'("123");
   localparam logic [55:0] C_SHAKE = 56'("Shake");
   localparam logic [55:0] C_BOGUS = 56'("Bogus");

   typedef struct packed {
      logic [55:0] a;
      logic [3:0]  u;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ld_we, start, start3;
   logic [2:0]  ld_idx;
   logic [71:0] ld_prompt, prompt1, prompt3, fixed_prompt;
   logic [55:0] ld_cmd;
   logic [3:0]  ld_u;
   logic [3:0]  num_steps;

   logic        rdy, busy, done, err, rdy3, busy3, done3, err3;
   logic [3:0]  u, u3;
   logic [55:0] a, a3;
   logic [2:0]  step, step3;
   logic [71:0] err_prompt, err_prompt3;

   int   n_checks = 0, n_fail = 0;
   int   cycle = 0, rdy_cnt = 0, t_prev = 0, t_last = 0;
   int   stub_idx = 0;
   logic stub_mode = 1'b0, stub_sel = 1'b0;
   exp_t sb_q[$];
   logic [55:0] a_hist [16];
   logic        r_hist [16];

   shop_cmd_driver #(.SETUP_CYCLES(1)) u_dut (
      .i_clk(clk), .i_reset(rst_n), .i_ld_we(ld_we), .i_ld_idx(ld_idx),
      .i_ld_prompt(ld_prompt), .i_ld_cmd(ld_cmd), .i_ld_u(ld_u),
      .i_num_steps(num_steps), .i_start(start), .i_prompt(prompt1),
      .o_rdy(rdy), .o_u(u), .o_a(a), .o_busy(busy), .o_done(done),
      .o_err(err), .o_step(step), .o_err_prompt(err_prompt));

   shop_cmd_driver #(.SETUP_CYCLES(3)) u_dut3 (
      .i_clk(clk), .i_reset(rst_n), .i_ld_we(ld_we), .i_ld_idx(ld_idx),
      .i_ld_prompt(ld_prompt), .i_ld_cmd(ld_cmd), .i_ld_u(ld_u),
      .i_num_steps(num_steps), .i_start(start3), .i_prompt(prompt3),
      .o_rdy(rdy3), .o_u(u3), .o_a(a3), .o_busy(busy3), .o_done(done3),
      .o_err(err3), .o_step(step3), .o_err_prompt(err_prompt3));

   // Stub shop: the prompt advances once per accepted command.
   always_comb begin
      prompt1 = fixed_prompt;
      if (stub_mode) begin
         if (!stub_sel) begin
            case (stub_idx)
               0:       prompt1 = P_CMD;
               1:       prompt1 = P_USER;
               2:       prompt1 = P_PASS;
               default: prompt1 = P_CMD;
            endcase
         end else begin
            prompt1 = (stub_idx == 0) ? P_CMD : P_GARB;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      exp_t e;
      @(negedge clk);
      cycle++;
      if (rdy) begin
         rdy_cnt++;
         t_prev = t_last;
         t_last = cycle;
         if (sb_q.size() == 0) begin
            chk("unexpected_rdy", 128'(rdy), 128'(0));
         end else begin
            e = sb_q.pop_front();
            chk("rdy_a", 128'(a), 128'(e.a));
            chk("rdy_u", 128'(u), 128'(e.u));
         end
         if (stub_mode) stub_idx++;
      end
   endtask

   task automatic push(input logic [55:0] ea, input logic [3:0] eu);
      exp_t e;
      e.a = ea;
      e.u = eu;
      sb_q.push_back(e);
   endtask

   task automatic load(input logic [2:0] idx, input logic [71:0] p,
                       input logic [55:0] c, input logic [3:0] uu);
      ld_we = 1'b1; ld_idx = idx; ld_prompt = p; ld_cmd = c; ld_u = uu;
      cyc();
      ld_we = 1'b0;
   endtask

   task automatic kick(input logic [3:0] n);
      num_steps = n;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (!(done || err) && n < 300) begin
         cyc();
         n++;
      end
      chk(tag, 128'({err, done}), 128'(2'b01));
   endtask

   task automatic load_login();
      load(3'd0, P_CMD,  C_LOGIN, 4'd1);
      load(3'd1, P_USER, C_ADM,   4'd2);
      load(3'd2, P_PASS, C_123,   4'd3);
   endtask

   initial begin
      int c0, n, k_rdy;
      rst_n = 1'b0; ld_we = 1'b0; start = 1'b0; start3 = 1'b0;
      ld_idx = '0; ld_prompt = '0; ld_cmd = '0; ld_u = '0; num_steps = 4'd1;
      fixed_prompt = '0; prompt3 = P_CMD;
      cyc(); cyc();
      chk("rst_rdy", 128'({rdy, rdy3}), 128'(0));
      chk("rst_flags", 128'({busy, done, err}), 128'(0));
      chk("rst_a_u", 128'({a, u}), 128'(0));
      chk("rst_step_errp", 128'({step, err_prompt}), 128'(0));
      rst_n = 1'b1;
      cyc();

      // Admin login flow
      stub_mode = 1'b1; stub_sel = 1'b0; stub_idx = 0;
      load_login();
      push(C_LOGIN, 4'd1); push(C_ADM, 4'd2); push(C_123, 4'd3);
      c0 = rdy_cnt;
      kick(4'd3);
      wait_end("t1_done");
      chk("t1_busy", 128'(busy), 128'(0));
      chk("t1_count", 128'(rdy_cnt - c0), 128'(3));
      chk("t1_queue", 128'(sb_q.size()), 128'(0));
      chk("t1_step", 128'(step), 128'(2));

      // Timeout on a wrong prompt
      stub_mode = 1'b0; fixed_prompt = P_INVAL;
      load(3'd0, P_CMD, C_LOGIN, 4'd1);
      c0 = rdy_cnt;
      kick(4'd1);
      n = 0;
      while (!err && n < 200) begin
         cyc();
         n++;
      end
      chk("t2_latency", 128'(n), 128'(64));
      chk("t2_step", 128'(step), 128'(0));
      chk("t2_err_prompt", 128'(err_prompt), 128'(P_INVAL));
      chk("t2_flags", 128'({busy, done}), 128'(0));
      chk("t2_no_rdy", 128'(rdy_cnt - c0), 128'(0));

      // Don't-care prompt on step 1
      stub_mode = 1'b1; stub_sel = 1'b1; stub_idx = 0;
      load(3'd0, P_CMD, C_LOGIN, 4'd1);
      load(3'd1, '0,    C_ADM,   4'd2);
      push(C_LOGIN, 4'd1); push(C_ADM, 4'd2);
      c0 = rdy_cnt;
      kick(4'd2);
      wait_end("t3_done");
      chk("t3_count", 128'(rdy_cnt - c0), 128'(2));
      chk("t3_step_gap", 128'(t_last - t_prev), 128'(4));
      chk("t3_errp_cleared", 128'(err_prompt), 128'(0));

      // Handshake timing with three setup cycles
      load(3'd0, P_CMD, C_SHAKE, 4'd5);
      num_steps = 4'd1;
      start3 = 1'b1;
      cyc();
      start3 = 1'b0;
      k_rdy = -1;
      a_hist[0] = a3; r_hist[0] = rdy3;
      for (int k = 1; k < 16; k++) begin
         cyc();
         a_hist[k] = a3;
         r_hist[k] = rdy3;
         if (rdy3 && k_rdy < 0) k_rdy = k;
      end
      chk("t4_rdy_pos", 128'(k_rdy), 128'(4));
      chk("t4_a_before_load", 128'(a_hist[0]), 128'(0));
      for (int j = 1; j < 4; j++) chk("t4_setup", 128'({r_hist[j], a_hist[j]}), 128'({1'b0, C_SHAKE}));
      chk("t4_strobe", 128'({r_hist[4], a_hist[4]}), 128'({1'b1, C_SHAKE}));
      chk("t4_hold", 128'({r_hist[5], a_hist[5]}), 128'({1'b0, C_SHAKE}));
      chk("t4_final", 128'({done3, busy3, err3, step3, u3}), 128'({1'b1, 1'b0, 1'b0, 3'd0, 4'd5}));
      chk("t4_errp", 128'(err_prompt3), 128'(0));

      // Reset during the second strobe, then replay
      stub_sel = 1'b0; stub_idx = 0;
      load_login();
      push(C_LOGIN, 4'd1); push(C_ADM, 4'd2);
      c0 = rdy_cnt;
      kick(4'd3);
      n = 0;
      while ((rdy_cnt - c0) < 2 && n < 100) begin
         cyc();
         n++;
      end
      chk("t5_reach_strobe", 128'({rdy_cnt - c0, 31'(0), rdy}), 128'({32'd2, 31'(0), 1'b1}));
      rst_n = 1'b0;
      #1;
      chk("t5_rdy_async", 128'(rdy), 128'(0));
      chk("t5_flags", 128'({busy, done, err}), 128'(0));
      chk("t5_data", 128'({a, u, step}), 128'(0));
      chk("t5_errp", 128'(err_prompt), 128'(0));
      cyc();
      rst_n = 1'b1; stub_idx = 0;
      cyc();
      chk("t5_idle", 128'({busy, done, err, rdy}), 128'(0));
      push(C_LOGIN, 4'd1); push(C_ADM, 4'd2); push(C_123, 4'd3);
      c0 = rdy_cnt;
      kick(4'd3);
      wait_end("t5_replay_done");
      chk("t5_replay_count", 128'(rdy_cnt - c0), 128'(3));
      chk("t5_queue", 128'(sb_q.size()), 128'(0));

      // Write and start while busy are ignored
      stub_idx = 0;
      push(C_LOGIN, 4'd1); push(C_ADM, 4'd2); push(C_123, 4'd3);
      c0 = rdy_cnt;
      kick(4'd3);
      cyc(); cyc();
      ld_we = 1'b1; ld_idx = 3'd0; ld_prompt = '0; ld_cmd = C_BOGUS; ld_u = 4'hF;
      start = 1'b1;
      cyc();
      ld_we = 1'b0; start = 1'b0;
      wait_end("t6_done");
      chk("t6_count", 128'(rdy_cnt - c0), 128'(3));
      chk("t6_queue", 128'(sb_q.size()), 128'(0));

      // Zero step count runs exactly one step with the untouched entry 0
      stub_idx = 0;
      push(C_LOGIN, 4'd1);
      c0 = rdy_cnt;
      kick(4'd0);
      wait_end("t6b_done");
      chk("t6b_count", 128'(rdy_cnt - c0), 128'(1));
      chk("t6b_step", 128'(step), 128'(0));
      chk("t6b_queue", 128'(sb_q.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
